// File: rtl/map_gen_pkg.sv
// map_gen_pkg: tile codes, LFSR constants and difficulty lookups shared by the map generator
package map_gen_pkg;
    localparam logic [1:0]  TILE_EMPTY = 2'b00;
    localparam logic [1:0]  TILE_BLOCK = 2'b01;
    localparam logic [1:0]  TILE_TALL  = 2'b10;
    localparam logic [15:0] LFSR_MASK  = 16'hB400;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    function automatic logic [7:0] thresh(input logic [1:0] d);
        return d == 2'd0 ? 8'd32 : d == 2'd1 ? 8'd64 : d == 2'd2 ? 8'd96 : 8'd128;
    endfunction

    function automatic logic [1:0] gap_len(input logic [1:0] d);
        return d == 2'd0 ? 2'd3 : d == 2'd3 ? 2'd1 : 2'd2;
    endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit right-shifting Galois LFSR with loadable seed that never locks up at zero
module lfsr16
    import map_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        step,
    output logic [15:0] q
);
    always_ff @(posedge clk)
        if (rst)
            q <= LFSR_SEED;
        else if (load)
            q <= load_val == 16'h0 ? LFSR_SEED : load_val;
        else if (step)
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0);
endmodule

// File: rtl/map_generator.sv
// map_generator: scrolls an 8-tile obstacle map one tile per game tick, inserting pseudo-random tiles
module map_generator
    import map_gen_pkg::*;
(
    input  logic        CLK100MHZ,
    input  logic        reset_btn,
    input  logic        clk_div,
    input  logic        start,
    input  logic        jump_btn,
    input  logic [1:0]  difficulty,
    output logic [15:0] map
);
    logic        s1, s2, s3, advance, obstacle;
    logic [15:0] free_cnt, lfsr;
    logic [1:0]  gap_cnt, new_tile;

    assign advance  = s2 & ~s3;
    assign obstacle = gap_cnt == 2'd0 && lfsr[7:0] < thresh(difficulty);
    assign new_tile = !obstacle ? TILE_EMPTY : (difficulty[1] && lfsr[8]) ? TILE_TALL : TILE_BLOCK;

    // seed entropy comes from when the player presses jump while idle
    lfsr16 u_lfsr (
        .clk     (CLK100MHZ),
        .rst     (reset_btn),
        .load    (!start && jump_btn),
        .load_val(free_cnt ^ LFSR_SEED),
        .step    (advance && start),
        .q       (lfsr)
    );

    always_ff @(posedge CLK100MHZ)
        if (reset_btn) begin
            {s1, s2, s3} <= 3'b000;
            free_cnt     <= 16'h0;
            gap_cnt      <= 2'd0;
            map          <= 16'h0;
        end else begin
            {s1, s2, s3} <= {clk_div, s1, s2};
            free_cnt     <= free_cnt + 16'd1;
            if (!start) begin
                map     <= 16'h0;
                gap_cnt <= 2'd0;
            end else if (advance) begin
                map     <= {new_tile, map[15:2]};
                gap_cnt <= obstacle ? gap_len(difficulty) : gap_cnt != 2'd0 ? gap_cnt - 2'd1 : 2'd0;
            end
        end
endmodule

// File: tb/tb_map_generator.sv
// tb_map_generator: randomized bench comparing map_generator against a tile-level reference model
module tb_map_generator;
    logic        CLK100MHZ = 0, reset_btn = 1, clk_div = 0, start = 0, jump_btn = 0;
    logic [1:0]  difficulty = 0;
    logic [15:0] map;
    int errors = 0, checks = 0;

    map_generator dut (
        .CLK100MHZ (CLK100MHZ),
        .reset_btn (reset_btn),
        .clk_div   (clk_div),
        .start     (start),
        .jump_btn  (jump_btn),
        .difficulty(difficulty),
        .map       (map)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int thr[4]  = '{32, 64, 96, 128};
    int gapl[4] = '{3, 2, 2, 1};
    int m_tiles[8];
    int m_lfsr = 'hACE1, m_gap = 0, m_fc = 0;
    bit m_c1, m_c2, m_c3;

    function automatic int next_tile(int lf, int g, int d);
        if (g != 0 || (lf % 256) >= thr[d]) return 0;
        return (d >= 2 && (lf / 256) % 2 == 1) ? 2 : 1;
    endfunction

    // reference model: tiles as integers, one shift per synchronized rising edge of clk_div
    always @(posedge CLK100MHZ) begin
        if (reset_btn) begin
            m_c1 <= 0; m_c2 <= 0; m_c3 <= 0;
            m_fc <= 0; m_lfsr <= 'hACE1; m_gap <= 0;
            for (int i = 0; i < 8; i++) m_tiles[i] <= 0;
        end else begin
            m_c1 <= clk_div; m_c2 <= m_c1; m_c3 <= m_c2;
            m_fc <= (m_fc + 1) % 65536;
            if (!start) begin
                for (int i = 0; i < 8; i++) m_tiles[i] <= 0;
                m_gap <= 0;
                if (jump_btn) m_lfsr <= (m_fc ^ 'hACE1) == 0 ? 'hACE1 : (m_fc ^ 'hACE1);
            end else if (m_c2 && !m_c3) begin
                for (int i = 0; i < 7; i++) m_tiles[i] <= m_tiles[i+1];
                m_tiles[7] <= next_tile(m_lfsr, m_gap, int'(difficulty));
                m_gap <= next_tile(m_lfsr, m_gap, int'(difficulty)) != 0 ? gapl[difficulty] : (m_gap > 0 ? m_gap - 1 : 0);
                m_lfsr <= (m_lfsr / 2) ^ ((m_lfsr % 2) != 0 ? 'hB400 : 0);
            end
        end
    end

    function automatic logic [15:0] m_map();
        logic [15:0] r = '0;
        for (int i = 0; i < 8; i++) r[2*i +: 2] = 2'(m_tiles[i]);
        return r;
    endfunction

    function automatic int min_dist(logic [15:0] m);
        int last = -100, best = 100;
        for (int i = 0; i < 8; i++)
            if (m[2*i +: 2] != 2'b00) begin
                if (i - last < best) best = i - last;
                last = i;
            end
        return best;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK100MHZ);
        check("map", map, m_map());
    endtask

    task automatic tick(input int hi, input int lo);
        clk_div = 1;
        repeat (hi) cyc();
        clk_div = 0;
        repeat (lo) cyc();
    endtask

    task automatic run(input int d, input int n, output int obst, output int talls);
        int bad = 0, sp = 0;
        obst = 0; talls = 0;
        difficulty = 2'(d);
        for (int k = 0; k < n; k++) begin
            tick($urandom_range(2, 4), $urandom_range(2, 4));
            if (map[15:14] != 2'b00) obst++;
            if (map[15:14] == 2'b10) talls++;
            if (map[15:14] == 2'b11 || (d < 2 && map[15:14] == 2'b10)) bad++;
            if (min_dist(map) < gapl[d] + 1) sp++;
        end
        check($sformatf("spacing_d%0d", d), sp, 0);
        check($sformatf("codes_d%0d", d), bad, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] pre, last;
        int n_chg, o0, t0, o3, t3;
        cyc();
        reset_btn = 0;
        check("reset_map", map, 0);
        for (int k = 0; k < 20; k++) begin
            tick(2, 2);
            check("idle_map", map, 0);
        end

        reset_btn = 1; cyc(); reset_btn = 0;
        start = 1; difficulty = 3;
        for (int k = 0; k < 16; k++) begin
            pre = m_map();
            tick(2, 2);
            check("shift_in", map[13:12], pre[15:14]);
        end

        pre = m_map();
        clk_div = 1;
        cyc(); cyc();
        check("lat_e2", map, pre);
        cyc();
        check("lat_e3", map[13:0], pre[15:2]);
        n_chg = 0; last = map;
        repeat (197) begin
            cyc();
            if (map != last) n_chg++;
            last = map;
        end
        clk_div = 0;
        repeat (3) cyc();
        check("hold_one_shift", n_chg, 0);

        start = 0; cyc();
        check("start_low_clear", map, 0);
        repeat ($urandom_range(1, 50)) cyc();
        jump_btn = 1; cyc(); jump_btn = 0;
        start = 1;
        run(0, 5000, o0, t0);

        start = 0; cyc();
        for (int k = 0; k < 70000 && m_fc != 'hACE1; k++) cyc();
        if (m_fc != 'hACE1) check("seed_wait", m_fc, 'hACE1);
        jump_btn = 1; cyc(); jump_btn = 0;
        start = 1; difficulty = 3;
        repeat (12) tick(2, 2);
        check("seed_guard", map, m_map());

        start = 0; cyc(); start = 1;
        run(3, 5000, o3, t3);
        check("tall_d3", t3 > 0, 1);
        check("density", o3 > o0, 1);

        clk_div = 1;
        cyc(); cyc();
        reset_btn = 1;
        cyc();
        check("reset_on_advance", map, 0);
        reset_btn = 0; clk_div = 0;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
